// File: rtl/cell_pkg.sv
// Shared constants and state encodings for the cell store and the cell fetcher.
// A frame is CELL_ROWS x CELL_COLS cells of CELL_WIDTH bits each.
package cell_pkg;

  localparam int CELL_WIDTH  = 768;
  localparam int CELL_ROWS   = 30;
  localparam int CELL_COLS   = 40;
  localparam int CELL_NUM    = CELL_ROWS * CELL_COLS;
  localparam int RD_LATENCY  = 2;
  localparam int CELL_ADDR_W = $clog2(CELL_NUM);
  // One extra bit so the request/return counters can hold CELL_NUM itself.
  localparam int CELL_CNT_W  = CELL_ADDR_W + 1;

  typedef enum logic {
    FILL_ST = 1'b0,
    READ_ST = 1'b1
  } cache_state_e;

endpackage

// File: rtl/cell_cache_rd_pipe.sv
// Frame memory plus its read pipe: a request in cycle T returns in T+RD_LATENCY
// (address/valid stage, then registered data stage). Out-of-range addresses read as zero.
module cell_cache_rd_pipe
  import cell_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [CELL_ADDR_W-1:0] wr_addr_i,
  input  logic [CELL_WIDTH-1:0]  wr_data_i,
  input  logic                   rd_en_i,
  input  logic [CELL_ADDR_W-1:0] rd_addr_i,
  output logic                   rd_rdy_o,
  output logic [CELL_WIDTH-1:0]  rd_data_o
);

  logic [CELL_WIDTH-1:0] mem [0:CELL_NUM-1];

  logic                   s1_vld_q, s1_vld_d;
  logic [CELL_ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic                   s1_in_range_q, s1_in_range_d;
  logic                   rdy_q, rdy_d;
  logic [CELL_WIDTH-1:0]  data_q, data_d;

  // Memory contents survive reset; only the pipe control is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    s1_vld_d      = rd_en_i;
    s1_addr_d     = rd_addr_i;
    s1_in_range_d = (rd_addr_i < CELL_ADDR_W'(CELL_NUM));
    rdy_d         = s1_vld_q;
    data_d        = data_q;
    if (s1_vld_q) begin
      data_d = s1_in_range_q ? mem[s1_addr_q] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_in_range_q <= 1'b0;
      rdy_q         <= 1'b0;
      data_q        <= '0;
    end else begin
      s1_vld_q      <= s1_vld_d;
      s1_addr_q     <= s1_addr_d;
      s1_in_range_q <= s1_in_range_d;
      rdy_q         <= rdy_d;
      data_q        <= data_d;
    end
  end

  assign rd_rdy_o  = rdy_q;
  assign rd_data_o = data_q;

endmodule

// File: rtl/cell_cache.sv
// Single-frame cell store: fills with CELL_NUM cells, pulses the fetcher start,
// serves CELL_NUM reads, then re-opens for the next frame.
module cell_cache
  import cell_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CELL_WIDTH-1:0]  bwd_cell_data_i,
  input  logic                   bwd_cell_valid_i,
  output logic                   bwd_cell_ready_o,
  output logic                   cell_fetch_start_o,
  input  logic [CELL_ADDR_W-1:0] fwd_cell_addr_i,
  input  logic                   fwd_cell_rd_vld_i,
  output logic [CELL_WIDTH-1:0]  fwd_cell_data_o,
  output logic                   fwd_cell_rd_rdy_o
);

  cache_state_e           state_q, state_d;
  logic [CELL_ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CELL_CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CELL_CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic                   start_q, start_d;

  logic wr_fire;
  logic rd_accept;
  logic rd_rdy;

  // Ready comes straight from the state register, so a write can never land
  // in the same cycle the state flips back to FILL_ST.
  assign bwd_cell_ready_o = (state_q == FILL_ST);
  assign wr_fire          = bwd_cell_valid_i && bwd_cell_ready_o;
  assign rd_accept        = (state_q == READ_ST) && fwd_cell_rd_vld_i &&
                            (req_cnt_q < CELL_CNT_W'(CELL_NUM));

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    req_cnt_d = req_cnt_q;
    ret_cnt_d = ret_cnt_q;
    start_d   = 1'b0;
    case (state_q)
      FILL_ST: begin
        if (wr_fire) begin
          if (wr_cnt_q == CELL_ADDR_W'(CELL_NUM - 1)) begin
            wr_cnt_d = '0;
            state_d  = READ_ST;
            start_d  = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + CELL_ADDR_W'(1);
          end
        end
      end
      READ_ST: begin
        if (rd_accept) begin
          req_cnt_d = req_cnt_q + CELL_CNT_W'(1);
        end
        // The last return implies every request was already accepted.
        if (rd_rdy) begin
          if (ret_cnt_q == CELL_CNT_W'(CELL_NUM - 1)) begin
            state_d   = FILL_ST;
            req_cnt_d = '0;
            ret_cnt_d = '0;
          end else begin
            ret_cnt_d = ret_cnt_q + CELL_CNT_W'(1);
          end
        end
      end
      default: state_d = FILL_ST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL_ST;
      wr_cnt_q  <= '0;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      req_cnt_q <= req_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      start_q   <= start_d;
    end
  end

  cell_cache_rd_pipe u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (bwd_cell_data_i),
    .rd_en_i   (rd_accept),
    .rd_addr_i (fwd_cell_addr_i),
    .rd_rdy_o  (rd_rdy),
    .rd_data_o (fwd_cell_data_o)
  );

  assign fwd_cell_rd_rdy_o  = rd_rdy;
  assign cell_fetch_start_o = start_q;

endmodule

// File: tb/tb_cell_cache.sv
// Directed bench for cell_cache: full frames, gapped and out-of-range reads,
// dropped requests, and an asynchronous reset in the middle of a read-out.
module tb_cell_cache;
  import cell_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CELL_WIDTH-1:0]  bwd_cell_data_i;
  logic                   bwd_cell_valid_i;
  logic                   bwd_cell_ready_o;
  logic                   cell_fetch_start_o;
  logic [CELL_ADDR_W-1:0] fwd_cell_addr_i;
  logic                   fwd_cell_rd_vld_i;
  logic [CELL_WIDTH-1:0]  fwd_cell_data_o;
  logic                   fwd_cell_rd_rdy_o;

  cell_cache dut (
    .clk                (clk),
    .rst                (rst),
    .bwd_cell_data_i    (bwd_cell_data_i),
    .bwd_cell_valid_i   (bwd_cell_valid_i),
    .bwd_cell_ready_o   (bwd_cell_ready_o),
    .cell_fetch_start_o (cell_fetch_start_o),
    .fwd_cell_addr_i    (fwd_cell_addr_i),
    .fwd_cell_rd_vld_i  (fwd_cell_rd_vld_i),
    .fwd_cell_data_o    (fwd_cell_data_o),
    .fwd_cell_rd_rdy_o  (fwd_cell_rd_rdy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int obs_ret;

  // Behavioural expectation: state, counters, one in-flight stage, held output.
  int                    m_state;
  int                    m_wr, m_req, m_ret;
  bit                    m_start, m_p1v, m_rdy;
  logic [CELL_WIDTH-1:0] m_p1d, m_dout;
  logic [CELL_WIDTH-1:0] m_mem [CELL_NUM];

  task automatic chk(input string tag, input logic [CELL_WIDTH-1:0] obs,
                     input logic [CELL_WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CELL_WIDTH-1:0] pat(input int f, input int i);
    logic [CELL_WIDTH-1:0] v;
    v = '0;
    v[31:0]    = i;
    v[767:752] = f[15:0];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wr = 0; m_req = 0; m_ret = 0;
    m_start = 0; m_p1v = 0; m_rdy = 0;
    m_p1d = '0; m_dout = '0;
  endtask

  // Called just after a falling edge with inputs set; advances one clock.
  task automatic step();
    bit old_read, wr_fire, acc, ret;
    logic [CELL_WIDTH-1:0] rd_d;
    old_read = (m_state == 1);
    wr_fire  = bwd_cell_valid_i && !old_read;
    acc      = old_read && fwd_cell_rd_vld_i && (m_req < CELL_NUM);
    rd_d     = (int'(fwd_cell_addr_i) < CELL_NUM) ? m_mem[fwd_cell_addr_i] : '0;
    ret      = m_rdy;
    @(posedge clk);
    @(negedge clk);
    m_rdy = m_p1v;
    if (m_p1v) m_dout = m_p1d;
    m_p1v   = acc;
    m_p1d   = rd_d;
    m_start = wr_fire && (m_wr == CELL_NUM - 1);
    if (wr_fire) begin
      m_mem[m_wr] = bwd_cell_data_i;
      if (m_wr == CELL_NUM - 1) begin
        m_wr = 0;
        m_state = 1;
      end else begin
        m_wr++;
      end
    end
    if (acc) m_req++;
    if (old_read && ret) begin
      if (m_ret == CELL_NUM - 1) begin
        m_state = 0; m_req = 0; m_ret = 0;
      end else begin
        m_ret++;
      end
    end
    if (fwd_cell_rd_rdy_o) obs_ret++;
    chk("rd_rdy", fwd_cell_rd_rdy_o, m_rdy);
    chk("rd_data", fwd_cell_data_o, m_dout);
    chk("wr_ready", bwd_cell_ready_o, m_state == 0);
    chk("fetch_start", cell_fetch_start_o, m_start);
  endtask

  task automatic write_frame(input int f, input bit rnd, input bit poke_rd);
    int guard = 0;
    while (m_state == 0 && guard < 20000) begin
      bwd_cell_valid_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bwd_cell_data_i   = pat(f, m_wr);
      fwd_cell_rd_vld_i = poke_rd ? 1'($urandom_range(0, 1)) : 1'b0;
      fwd_cell_addr_i   = CELL_ADDR_W'($urandom_range(0, CELL_NUM - 1));
      step();
      guard++;
    end
    bwd_cell_valid_i  = 1'b0;
    fwd_cell_rd_vld_i = 1'b0;
    chk("fill_start_pulse", cell_fetch_start_o, 1'b1);
    chk("fill_ready_low", bwd_cell_ready_o, 1'b0);
  endtask

  // Reads with address = request index; optional gaps and out-of-range probes.
  // Write valid is held high with junk data to prove no write leaks in READ_ST.
  task automatic read_frame(input bit gaps, input bit odd_addrs, input int stop_after);
    int guard = 0;
    obs_ret = 0;
    bwd_cell_valid_i = 1'b1;
    bwd_cell_data_i  = {CELL_WIDTH{1'b1}};
    while (m_state == 1 && guard < 20000 && (stop_after == 0 || obs_ret < stop_after)) begin
      fwd_cell_rd_vld_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (odd_addrs && m_req == 5)       fwd_cell_addr_i = CELL_ADDR_W'(1200);
      else if (odd_addrs && m_req == 9)  fwd_cell_addr_i = CELL_ADDR_W'(2047);
      else if (m_req < CELL_NUM)         fwd_cell_addr_i = CELL_ADDR_W'(m_req);
      else                               fwd_cell_addr_i = '0;
      step();
      guard++;
    end
    bwd_cell_valid_i = 1'b0;
    if (stop_after == 0) begin
      fwd_cell_rd_vld_i = 1'b0;
      chk("read_total_returns", 32'(obs_ret), 32'(CELL_NUM));
      chk("read_end_ready", bwd_cell_ready_o, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bwd_cell_valid_i  = 1'b0;
    bwd_cell_data_i   = '0;
    fwd_cell_rd_vld_i = 1'b0;
    fwd_cell_addr_i   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", bwd_cell_ready_o, 1'b1);
    chk("reset_start", cell_fetch_start_o, 1'b0);
    chk("reset_rd_rdy", fwd_cell_rd_rdy_o, 1'b0);
    chk("reset_data", fwd_cell_data_o, '0);

    // Requests while filling must vanish.
    fwd_cell_rd_vld_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fwd_cell_addr_i = CELL_ADDR_W'(i);
      step();
    end
    fwd_cell_rd_vld_i = 1'b0;

    // Frame 0: data = index, back-to-back read-out starting at the start pulse.
    write_frame(0, 1'b0, 1'b0);
    read_frame(1'b0, 1'b0, 0);

    // Frame 1: ragged writes with stray reads, gapped reads with out-of-range
    // addresses and surplus requests after the 1200th.
    write_frame(1, 1'b1, 1'b1);
    read_frame(1'b1, 1'b1, 0);

    // Frame 2: asynchronous reset after 600 returns.
    write_frame(2, 1'b0, 1'b0);
    read_frame(1'b0, 1'b0, 600);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", bwd_cell_ready_o, 1'b1);
    chk("async_rst_rd_rdy", fwd_cell_rd_rdy_o, 1'b0);
    chk("async_rst_data", fwd_cell_data_o, '0);
    chk("async_rst_start", cell_fetch_start_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    fwd_cell_rd_vld_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fwd_cell_addr_i = CELL_ADDR_W'(i);
      step();
    end
    fwd_cell_rd_vld_i = 1'b0;

    // Frame 3: a clean frame after the reset.
    write_frame(3, 1'b0, 1'b0);
    read_frame(1'b0, 1'b0, 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cell_cache.md
# cell_cache

Single-frame cell store sitting between the cell-producing front end and the cell fetcher that feeds HOG. It accepts a full frame of CELL_NUM cells on a valid/ready write port, signals the fetcher to start, then answers the fetcher's address/read-valid requests with data and a read-ready strobe exactly two cycles later. Once the frame has been read out completely, it re-opens for the next frame.

## Interface
- CELL_WIDTH, 768, bits per cell word
- CELL_NUM, 1200, cells per frame (30 rows x 40 cols)
- RD_LATENCY, 2, read latency in cycles; fixed, must equal the fetcher's skid depth
- CELL_ADDR_W, $clog2(CELL_NUM), derived, not configured
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- bwd_cell_data_i  in  CELL_WIDTH  cell to store
- bwd_cell_valid_i  in  1  write valid
- bwd_cell_ready_o  out  1  write ready; high only in FILL_ST
- cell_fetch_start_o  out  1  one-cycle pulse: frame complete, fetcher may start
- fwd_cell_addr_i  in  CELL_ADDR_W  read address
- fwd_cell_rd_vld_i  in  1  read request
- fwd_cell_data_o  out  CELL_WIDTH  read data, valid with fwd_cell_rd_rdy_o
- fwd_cell_rd_rdy_o  out  1  read-data strobe

## Operation
- States: FILL_ST (reset state), READ_ST.
- FILL_ST: bwd_cell_ready_o=1. On valid&ready, write mem[wr_cnt], wr_cnt++. When the write at wr_cnt==CELL_NUM-1 occurs: wr_cnt←0, state←READ_ST, cell_fetch_start_o=1 in the next cycle.
- READ_ST: bwd_cell_ready_o=0. A request (rd_vld=1) is accepted while req_cnt<CELL_NUM; on acceptance, req_cnt++ and the address enters the read pipe. Each returned word pulses fwd_cell_rd_rdy_o and increments ret_cnt. When the return at ret_cnt==CELL_NUM-1 occurs: req_cnt, ret_cnt←0, state←FILL_ST.
- Requests made in FILL_ST, or once req_cnt==CELL_NUM, are dropped: no pipe entry, no rd_rdy.
- Address ≥CELL_NUM is accepted and counted, and returns all-zero data.
- Read side has no backpressure; the fetcher absorbs stalls in its own skid buffer.
- Reset values: bwd_cell_ready_o=1 once reset is released (state FILL_ST), cell_fetch_start_o=0, fwd_cell_rd_rdy_o=0, fwd_cell_data_o=0. All counters and pipe valids are cleared. Memory contents are not reset.
- Reset mid-frame discards the partial write or read. The next frame restarts at address 0.

## Timing
- Read: rd_vld accepted in cycle T with addr A → rd_rdy=1 in T+2 and data=mem[A]. Fully pipelined: back-to-back requests give back-to-back returns.
- Data is registered at the output and held (not cleared) when rd_rdy=0.
- cell_fetch_start_o is registered: it rises the cycle after the last write and lasts exactly 1 cycle. Reads are accepted from that same cycle.
- Last return and bwd_cell_valid_i in the same cycle: ready is still 0 (state register), and the write is taken in the next cycle at the earliest.
- Write in the same cycle as the state flip to FILL_ST is impossible, because ready is derived from the registered state.
- Counter widths: CELL_ADDR_W+1 bits for req/ret so the value CELL_NUM is representable.

## Structure
- Shared package cell_pkg: CELL_WIDTH, CELL_NUM, row/col counts, and FILL_ST/READ_ST encodings. The same constants serve cell_fetch.
- One sub-module, cell_cache_rd_pipe: a RD_LATENCY-deep valid+address pipe that performs the memory read and the out-of-range zeroing.
- Memory is an inferred single-write, single-read array, with no byte enables.

## Test plan
- Reset, then write cells 0..1199 with data=index → cell_fetch_start_o pulses once in the cycle after write 1199, and bwd_cell_ready_o falls in that same cycle.
- Issue 1200 back-to-back reads, addr 0..1199, starting at the start pulse → 1200 consecutive rd_rdy pulses, each 2 cycles after its request, data=index. The state then returns to FILL_ST and ready=1.
- Reads with random gaps, plus requests sent during FILL_ST → dropped requests produce no rd_rdy. Every accepted request returns exactly once at +2 cycles.
- Address 1200 and 2047 in READ_ST → rd_rdy at +2 with data=0, and each counts toward the 1200-return total.
- Write with valid toggling randomly, and 1201+ requests in one frame → no extra writes or returns. The second frame starts writing at address 0.
- Assert rst asynchronously mid-read (after 600 returns) → outputs drop to reset values immediately, with no further rd_rdy. A new full frame then works normally.
